// File: rtl/mynet_pkg.sv
// Activation types shared between the window generator and the ternary adder.
package mynet_pkg;

  localparam int ACT_W = 6;

  typedef logic signed [ACT_W-1:0] act_t;

endpackage

// File: rtl/line_buffer_ram.sv
// Single-port line buffer: combinational read of the old word, synchronous write of the new one.
module line_buffer_ram
  import mynet_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  act_t                 wdata,
  output act_t                 rdata
);

  act_t mem [DEPTH];

  assign rdata = mem[addr];

  // Contents are deliberately left unreset; rows 0-1 of a frame are never fired.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator: two line buffers feed a 3x3 tap array that
// presents every fully-populated neighbourhood of a raster-order frame.
module window_gen_3x3
  import mynet_pkg::*;
#(
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16,
  parameter int ADDR_BITS  = 4,
  parameter int ROW_BITS   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  act_t in_data,
  input  logic sof,
  output act_t x11,
  output act_t x12,
  output act_t x13,
  output act_t x21,
  output act_t x22,
  output act_t x23,
  output act_t x31,
  output act_t x32,
  output act_t x33,
  output logic fire,
  output logic frame_done
);

  localparam logic [ADDR_BITS-1:0] COL_LAST = ADDR_BITS'(IMG_WIDTH - 1);
  localparam logic [ROW_BITS-1:0]  ROW_LAST = ROW_BITS'(IMG_HEIGHT - 1);

  logic [ADDR_BITS-1:0] col_reg, col_next, pc;
  logic [ROW_BITS-1:0]  row_reg, row_next, pr;
  logic                 fire_reg, frame_done_reg;
  act_t                 lb1_rd, lb2_rd;
  act_t                 col_in [3];

  // sof forces the current pixel to (0,0), even mid-frame.
  assign pc = sof ? '0 : col_reg;
  assign pr = sof ? '0 : row_reg;

  always_comb begin
    col_next = pc + ADDR_BITS'(1);
    row_next = pr;
    if (pc == COL_LAST) begin
      col_next = '0;
      row_next = (pr == ROW_LAST) ? '0 : pr + ROW_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg        <= '0;
      row_reg        <= '0;
      fire_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      fire_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      if (in_valid) begin
        col_reg        <= col_next;
        row_reg        <= row_next;
        fire_reg       <= (pr >= ROW_BITS'(2)) && (pc >= ADDR_BITS'(2));
        frame_done_reg <= !sof && (pr == ROW_LAST) && (pc == COL_LAST);
      end
    end
  end

  line_buffer_ram #(
    .DEPTH    (IMG_WIDTH),
    .ADDR_BITS(ADDR_BITS)
  ) u_lb1 (
    .clk  (clk),
    .we   (in_valid),
    .addr (pc),
    .wdata(in_data),
    .rdata(lb1_rd)
  );

  line_buffer_ram #(
    .DEPTH    (IMG_WIDTH),
    .ADDR_BITS(ADDR_BITS)
  ) u_lb2 (
    .clk  (clk),
    .we   (in_valid),
    .addr (pc),
    .wdata(lb1_rd),
    .rdata(lb2_rd)
  );

  // Tap row 0 is the oldest image row, row 2 the current one.
  assign col_in[0] = lb2_rd;
  assign col_in[1] = lb1_rd;
  assign col_in[2] = in_data;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      act_t tap_reg [3];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tap_reg[0] <= '0;
          tap_reg[1] <= '0;
          tap_reg[2] <= '0;
        end else if (in_valid) begin
          tap_reg[0] <= tap_reg[1];
          tap_reg[1] <= tap_reg[2];
          tap_reg[2] <= col_in[gi];
        end
      end
    end
  endgenerate

  assign x11 = g_row[0].tap_reg[0];
  assign x12 = g_row[0].tap_reg[1];
  assign x13 = g_row[0].tap_reg[2];
  assign x21 = g_row[1].tap_reg[0];
  assign x22 = g_row[1].tap_reg[1];
  assign x23 = g_row[1].tap_reg[2];
  assign x31 = g_row[2].tap_reg[0];
  assign x32 = g_row[2].tap_reg[1];
  assign x33 = g_row[2].tap_reg[2];

  assign fire       = fire_reg;
  assign frame_done = frame_done_reg;

endmodule
